lane_del_conn_array: RTL and testbench

- Parametrised successor to the single deletion lane: NUM_LANES genes per beat pass through NUM_LANES parallel connection-deletion lanes.
- Applies a per-lane LFSR draw against conn_del_prob, enforces a per-genome deletion limit across all lanes, and tracks the max hidden node ID of surviving genes.
- Sits between the genome reader and the crossover/writeback stage; valid/ready on both sides.

---
 rtl/lane_del_conn_array.sv | 171 +++++++++++++++++
 tb/tb_lane_del_conn_array.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_del_conn_array.sv
// Parallel connection-deletion lanes: NUM_LANES genes per beat, each lane draws from its
// own 16-bit Galois LFSR and deletes its gene when the draw is under conn_del_prob, subject
// to a per-genome deletion limit (low lane index wins). Tracks the max hidden node ID of kept
// genes. One register stage, valid/ready on both sides.
// Optional: define LANE_STATS_EN to add o_stat_del_total, a saturating count of all deletions.
module lane_del_conn_array #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned GENE_SZ   = 64,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned PROB_W    = 8,
  parameter int unsigned LIM_DEL   = 8,
  parameter int unsigned NUM_IO    = 4,
  parameter logic [15:0] SEED      = 16'hACE1,
  localparam int unsigned CNT_W    = $clog2(LIM_DEL + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_state,
  input  logic [PROB_W-1:0]            i_conn_del_prob,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic                         i_in_last,
  input  logic [NUM_LANES-1:0]         i_in_mask,
  input  logic [NUM_LANES*GENE_SZ-1:0] i_gene_in,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic                         o_out_last,
  output logic [NUM_LANES-1:0]         o_out_keep,
  output logic [NUM_LANES*GENE_SZ-1:0] o_gene_out,
  output logic [ID_W-1:0]              o_hidden_node_max,
  output logic [CNT_W-1:0]             o_del_count
`ifdef LANE_STATS_EN
  ,
  output logic [31:0]                  o_stat_del_total
`endif
);

  localparam logic [CNT_W-1:0] LimC = CNT_W'(LIM_DEL);
  localparam logic [ID_W-1:0]  IoC  = ID_W'(NUM_IO);

  typedef enum logic [0:0] {StIdle, StActive} fsm_e;

  fsm_e                         r_fsm, w_fsm_next;
  logic                         r_state_lat;
  logic                         w_state_eff;
  logic                         w_accept;
  logic                         w_start;
  logic [15:0]                  r_lfsr [NUM_LANES];
  logic [NUM_LANES-1:0]         w_del;
  logic [NUM_LANES-1:0]         w_keep;
  logic [CNT_W-1:0]             r_del_cnt, w_del_base, w_del_next;
  logic [ID_W-1:0]              r_node_max, w_max_base, w_max_next;
  logic [ID_W-1:0]              w_in_node, w_out_node;
  logic                         r_out_valid;
  logic                         r_out_last;
  logic [NUM_LANES-1:0]         r_out_keep;
  logic [NUM_LANES*GENE_SZ-1:0] r_gene_out;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign o_in_ready  = !r_out_valid | i_out_ready;
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_start     = w_accept & (r_fsm == StIdle);
  // The first beat of a genome uses the live state input and fresh counters.
  assign w_state_eff = (r_fsm == StIdle) ? i_state : r_state_lat;
  assign w_del_base  = (r_fsm == StIdle) ? '0 : r_del_cnt;
  assign w_max_base  = (r_fsm == StIdle) ? '0 : r_node_max;

  // Genome framing state and latched enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm       <= StIdle;
      r_state_lat <= 1'b0;
    end else begin
      r_fsm <= w_fsm_next;
      if (w_start) r_state_lat <= i_state;
    end
  end

  // Next-state: a beat with last closes the genome, anything else keeps it open.
  always_comb begin
    w_fsm_next = r_fsm;
    unique case (r_fsm)
      StIdle:   if (w_accept && !i_in_last) w_fsm_next = StActive;
      StActive: if (w_accept && i_in_last)  w_fsm_next = StIdle;
      default:  w_fsm_next = StIdle;
    endcase
  end

  // Per-lane deletion decision with limit priority, and running hidden-node max.
  always_comb begin
    w_del_next = w_del_base;
    w_max_next = w_max_base;
    w_del      = '0;
    w_keep     = '0;
    w_in_node  = '0;
    w_out_node = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_out_node = i_gene_in[i*GENE_SZ +: ID_W];
      w_in_node  = i_gene_in[i*GENE_SZ+ID_W +: ID_W];
      if (w_state_eff && i_in_mask[i] && (r_lfsr[i][PROB_W-1:0] < i_conn_del_prob) &&
          (w_del_next < LimC)) begin
        w_del[i]   = 1'b1;
        w_del_next = w_del_next + CNT_W'(1);
      end
      w_keep[i] = i_in_mask[i] & !w_del[i];
      if (w_keep[i]) begin
        if (w_in_node >= IoC && w_in_node > w_max_next)   w_max_next = w_in_node;
        if (w_out_node >= IoC && w_out_node > w_max_next) w_max_next = w_out_node;
      end
    end
  end

  // Lane LFSRs advance together on every accepted beat, mask notwithstanding.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) r_lfsr[i] <= SEED ^ 16'(i + 1);
    end else if (w_accept) begin
      for (int i = 0; i < NUM_LANES; i++) r_lfsr[i] <= lfsr_adv(r_lfsr[i]);
    end
  end

  // Output register stage; genome totals update only on accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_keep  <= '0;
      r_gene_out  <= '0;
      r_del_cnt   <= '0;
      r_node_max  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_last  <= i_in_last;
      r_out_keep  <= w_keep;
      r_gene_out  <= i_gene_in;
      r_del_cnt   <= w_del_next;
      r_node_max  <= w_max_next;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid       = r_out_valid;
  assign o_out_last        = r_out_last;
  assign o_out_keep        = r_out_keep;
  assign o_gene_out        = r_gene_out;
  assign o_del_count       = r_del_cnt;
  assign o_hidden_node_max = r_node_max;

`ifdef LANE_STATS_EN
  logic [31:0] r_stat_total;
  logic [32:0] w_stat_sum;

  assign w_stat_sum = {1'b0, r_stat_total} + 33'($countones(w_del));

  // Lifetime deletion total, saturating at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stat_total <= '0;
    end else if (w_accept) begin
      r_stat_total <= w_stat_sum[32] ? 32'hFFFF_FFFF : w_stat_sum[31:0];
    end
  end

  assign o_stat_del_total = r_stat_total;
`endif

endmodule

// File: tb/tb_lane_del_conn_array.sv
// Bench for lane_del_conn_array: constant-expectation vector table, hand-built corner
// sequences and a randomized run, all against a behavioural genome-level model.
module tb_lane_del_conn_array;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         st;
  logic [7:0]   prob;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [3:0]   in_mask;
  logic [255:0] gene_in;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [3:0]   out_keep;
  logic [255:0] gene_out;
  logic [7:0]   hmax;
  logic [3:0]   dcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lane_del_conn_array dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_state           (st),
    .i_conn_del_prob   (prob),
    .i_in_valid        (in_valid),
    .o_in_ready        (in_ready),
    .i_in_last         (in_last),
    .i_in_mask         (in_mask),
    .i_gene_in         (gene_in),
    .o_out_valid       (out_valid),
    .i_out_ready       (out_ready),
    .o_out_last        (out_last),
    .o_out_keep        (out_keep),
    .o_gene_out        (gene_out),
    .o_hidden_node_max (hmax),
    .o_del_count       (dcnt)
  );

  // ---------------- reference model ----------------
  logic [15:0]  m_lfsr [4];
  bit           m_active, m_st, m_ov, m_last;
  int           m_del;
  logic [7:0]   m_max;
  logic [3:0]   m_keep;
  logic [255:0] m_gene;

  function automatic logic [15:0] adv(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_lfsr[i] = 16'hACE1 ^ 16'(i + 1);
    m_active = 0; m_st = 0; m_ov = 0; m_last = 0;
    m_del = 0; m_max = 0; m_keep = 0; m_gene = 0;
  endtask

  task automatic model_accept(input bit s, input logic [7:0] p, input logic [3:0] mask,
                              input bit last, input logic [255:0] genes);
    logic [7:0] draw, nin, nout;
    bit kill;
    if (!m_active) begin
      m_st = s; m_del = 0; m_max = 0;
    end
    for (int i = 0; i < 4; i++) begin
      draw = m_lfsr[i][7:0];
      m_lfsr[i] = adv(m_lfsr[i]);
      kill = m_st && mask[i] && (draw < p) && (m_del < 8);
      if (kill) m_del++;
      m_keep[i] = mask[i] && !kill;
      nout = genes[i*64 +: 8];
      nin  = genes[i*64+8 +: 8];
      if (m_keep[i]) begin
        if (nin >= 4 && nin > m_max)   m_max = nin;
        if (nout >= 4 && nout > m_max) m_max = nout;
      end
    end
    m_active = !last;
    m_last   = last;
    m_gene   = genes;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus, called #1 after a rising edge; checks the DUT after the next edge.
  task automatic cycle(input bit v, input bit rdy, input bit s, input logic [7:0] p,
                       input logic [3:0] mask, input bit last, input logic [255:0] genes);
    bit exp_rdy, acc;
    in_valid = v; out_ready = rdy; st = s; prob = p;
    in_mask = mask; in_last = last; gene_in = genes;
    #1;
    exp_rdy = !m_ov || rdy;
    chk("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy;
    if (acc) model_accept(s, p, mask, last, genes);
    m_ov = acc ? 1'b1 : (rdy ? 1'b0 : m_ov);
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("del_count", dcnt, m_del);
    chk("hidden_node_max", hmax, m_max);
    if (m_ov) begin
      chk("out_last", out_last, m_last);
      chk("out_keep", out_keep, m_keep);
      chk("gene_out", gene_out, m_gene);
    end
  endtask

  function automatic logic [255:0] mkgenes(input int row, input logic [31:0] inn,
                                           input logic [31:0] outn);
    logic [255:0] g;
    for (int i = 0; i < 4; i++)
      g[i*64 +: 64] = {16'hC0DE, 16'(row), 16'(i), inn[i*8 +: 8], outn[i*8 +: 8]};
    return g;
  endfunction

  function automatic logic [255:0] rnd_genes();
    logic [255:0] g;
    for (int i = 0; i < 8; i++) g[i*32 +: 32] = $urandom;
    return g;
  endfunction

  typedef struct {
    bit         s;
    logic [7:0] p;
    logic [3:0] mask;
    bit         last;
    logic [31:0] inn;
    logic [31:0] outn;
    bit         fixed;
    logic [3:0] ekeep;
    logic [3:0] edel;
    logic [7:0] emax;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [255:0] g;
    bit all_cand;
    int pre_del;

    tbl[0] = '{1'b0, 8'hFF, 4'hF, 1'b0, 32'h03020100, 32'h00010203, 1'b1, 4'hF, 4'd0, 8'd0};
    tbl[1] = '{1'b0, 8'hFF, 4'hF, 1'b0, 32'h03020100, 32'h07010203, 1'b1, 4'hF, 4'd0, 8'd7};
    tbl[2] = '{1'b0, 8'hFF, 4'hF, 1'b1, 32'h01010101, 32'h00000000, 1'b1, 4'hF, 4'd0, 8'd7};
    tbl[3] = '{1'b1, 8'h00, 4'hF, 1'b0, 32'h01010305, 32'h00000209, 1'b1, 4'hF, 4'd0, 8'd9};
    tbl[4] = '{1'b1, 8'h00, 4'hF, 1'b1, 32'h0000000C, 32'h01010103, 1'b1, 4'hF, 4'd0, 8'd12};
    tbl[5] = '{1'b0, 8'h00, 4'h5, 1'b1, 32'h0002C806, 32'h00010004, 1'b1, 4'h5, 4'd0, 8'd6};
    tbl[6] = '{1'b1, 8'hFF, 4'hF, 1'b0, 32'h11223344, 32'h55667788, 1'b0, 4'h0, 4'd0, 8'd0};
    tbl[7] = '{1'b1, 8'hFF, 4'hF, 1'b0, 32'h99AABBCC, 32'h0D0E0F10, 1'b0, 4'h0, 4'd0, 8'd0};
    tbl[8] = '{1'b1, 8'hFF, 4'hF, 1'b1, 32'h20212223, 32'h30313233, 1'b0, 4'h0, 4'd0, 8'd0};
    tbl[9] = '{1'b0, 8'h80, 4'hA, 1'b1, 32'hF0000050, 32'h00600000, 1'b1, 4'hA, 4'd0, 8'd240};

    in_valid = 0; out_ready = 1; st = 0; prob = 0; in_mask = 0; in_last = 0; gene_in = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_keep", out_keep, 0);
    chk("rst_gene_out", gene_out, 0);
    chk("rst_del_count", dcnt, 0);
    chk("rst_hmax", hmax, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Vector table: deterministic rows also carry constant expectations.
    for (int k = 0; k < 10; k++) begin
      cycle(1, 1, tbl[k].s, tbl[k].p, tbl[k].mask, tbl[k].last,
            mkgenes(k, tbl[k].inn, tbl[k].outn));
      if (tbl[k].fixed) begin
        chk($sformatf("tbl%0d_keep", k), out_keep, tbl[k].ekeep);
        chk($sformatf("tbl%0d_del", k), dcnt, tbl[k].edel);
        chk($sformatf("tbl%0d_hmax", k), hmax, tbl[k].emax);
        chk($sformatf("tbl%0d_last", k), out_last, tbl[k].last);
      end
    end
    cycle(0, 1, 0, 0, 0, 0, 0);

    // Limit straddle: three 2-lane beats then a full beat at max probability.
    for (int b = 0; b < 3; b++) cycle(1, 1, 1, 8'hFF, 4'h3, 0, mkgenes(20 + b, 0, 0));
    pre_del  = m_del;
    all_cand = 1;
    for (int i = 0; i < 4; i++) if (m_lfsr[i][7:0] == 8'hFF) all_cand = 0;
    cycle(1, 1, 1, 8'hFF, 4'hF, 1, mkgenes(23, 0, 0));
    if (pre_del == 6 && all_cand) begin
      chk("straddle_keep", out_keep, 4'hC);
      chk("straddle_del", dcnt, 4'd8);
    end

    // Back-pressure: second beat held off for five cycles, then accepted exactly once.
    cycle(1, 1, 1, 8'h90, 4'hF, 0, mkgenes(30, 32'h40414243, 32'h50515253));
    g = mkgenes(31, 32'h60616263, 32'h70717273);
    for (int c = 0; c < 5; c++) cycle(1, 0, 1, 8'h90, 4'hF, 1, g);
    cycle(1, 1, 1, 8'h90, 4'hF, 1, g);
    cycle(0, 1, 0, 0, 0, 0, 0);
    chk("stall_drained", out_valid, 0);

    // Reset in the middle of a genome.
    cycle(1, 1, 1, 8'hC0, 4'hF, 0, mkgenes(40, 32'h0A0B0C0D, 0));
    cycle(1, 1, 1, 8'hC0, 4'hF, 0, mkgenes(41, 32'h1A1B1C1D, 0));
    in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_keep", out_keep, 0);
    chk("mid_rst_gene", gene_out, 0);
    chk("mid_rst_del", dcnt, 0);
    chk("mid_rst_hmax", hmax, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    cycle(1, 1, 1, 8'hC0, 4'hF, 1, mkgenes(42, 32'h2A2B2C2D, 0));

    // Randomized traffic with random back-pressure.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] p;
      case ($urandom_range(0, 3))
        0: p = 8'h00;
        1: p = 8'hFF;
        default: p = 8'($urandom);
      endcase
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom), p,
            4'($urandom), $urandom_range(0, 3) == 0, rnd_genes());
    end
    cycle(0, 1, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
